// File: rtl/grad_descent_1d_pkg.sv
// Shared types and fixed-point helpers for the 1-D gradient-descent engine.
// Build option: define GD_SATURATE_EN to saturate all Q8.8 arithmetic instead of wrapping.
package gd_pkg;

    localparam int unsigned FX_W    = 16;
    localparam int unsigned FX_FRAC = 8;

    localparam logic [FX_W-1:0] FX_MAX = 16'h7FFF;
    localparam logic [FX_W-1:0] FX_MIN = 16'h8000;

`ifdef GD_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        GRAD,
        STEP,
        UPDATE,
        DONE
    } state_t;

    function automatic logic [FX_W:0] fx_sext(input logic [FX_W-1:0] v);
        return {v[FX_W-1], v};
    endfunction

    // Narrow an exact 17-bit signed result back to Q8.8, clamping or wrapping.
    function automatic logic [FX_W-1:0] fx_fit(input logic [FX_W:0] v);
        if (SAT_EN && (v[FX_W] != v[FX_W-1]))
            return v[FX_W] ? FX_MIN : FX_MAX;
        return v[FX_W-1:0];
    endfunction

endpackage

// File: rtl/grad_descent_1d_if.sv
// Request/result bundle of grad_descent_1d: operands, start, and the valid/ready result.
interface grad_descent_1d_if
    import gd_pkg::*;
#(
    parameter int unsigned ITER_W = 8
);
    logic              start;
    logic [FX_W-1:0]   coef_a;
    logic [FX_W-1:0]   coef_b;
    logic [FX_W-1:0]   lr;
    logic [FX_W-1:0]   x_init;
    logic [FX_W-1:0]   eps;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [FX_W-1:0]   x_out;
    logic [ITER_W-1:0] iter_count;
    logic              converged;

    modport master (
        output start, coef_a, coef_b, lr, x_init, eps, out_ready,
        input  busy, out_valid, x_out, iter_count, converged
    );

    modport slave (
        input  start, coef_a, coef_b, lr, x_init, eps, out_ready,
        output busy, out_valid, x_out, iter_count, converged
    );
endinterface

// File: rtl/grad_descent_1d_mul.sv
// fx_mul_q88: signed Q8.8 multiply, result is product bits [23:8] (floor shift).
// Overflow of the shifted product clamps when GD_SATURATE_EN is defined, else wraps.
module fx_mul_q88
    import gd_pkg::*;
(
    input  logic [FX_W-1:0] i_a,
    input  logic [FX_W-1:0] i_b,
    output logic [FX_W-1:0] o_p
);
    logic signed [2*FX_W-1:0]  w_prod;
    logic [FX_W-FX_FRAC:0]     w_top;
    logic                      w_ovf;
    logic                      w_unused_frac;

    assign w_prod = $signed(i_a) * $signed(i_b);

    // Shifted result fits in 16 bits only when the top 9 product bits agree.
    assign w_top         = w_prod[2*FX_W-1 : FX_W+FX_FRAC-1];
    assign w_ovf         = SAT_EN && (w_top != '0) && (w_top != '1);
    assign w_unused_frac = ^w_prod[FX_FRAC-1:0];

    assign o_p = w_ovf ? (w_prod[2*FX_W-1] ? FX_MIN : FX_MAX)
                       : w_prod[FX_FRAC +: FX_W];
endmodule

// File: rtl/grad_descent_1d.sv
// Iterative gradient descent on f(x) = a*x^2 + b*x in Q8.8: x <- x - lr*(2a*x + b).
// Three cycles per iteration; GD_SATURATE_EN selects saturating arithmetic.
module grad_descent_1d
    import gd_pkg::*;
#(
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned ITER_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    grad_descent_1d_if.slave bus
);
    state_t            r_state;
    logic [FX_W-1:0]   r_a, r_b, r_lr, r_eps;
    logic [FX_W-1:0]   r_x, r_g, r_s, r_x_out;
    logic [ITER_W-1:0] r_iter;
    logic              r_busy, r_valid, r_conv;

    logic [FX_W-1:0]   w_ax, w_dbl, w_g, w_s, w_x_nx;
    logic [FX_W:0]     w_s_abs;
    logic [ITER_W-1:0] w_iter_nx;
    logic              w_conv_hit, w_cap_hit;

    fx_mul_q88 u_mul_ax   (.i_a(r_a),  .i_b(r_x), .o_p(w_ax));
    fx_mul_q88 u_mul_step (.i_a(r_lr), .i_b(r_g), .o_p(w_s));

    assign w_dbl  = fx_fit({w_ax, 1'b0});
    assign w_g    = fx_fit(fx_sext(w_dbl) + fx_sext(r_b));
    assign w_x_nx = fx_fit(fx_sext(r_x) - fx_sext(r_s));

    // 17-bit magnitude so that |-128.0| is +32768 rather than wrapping negative.
    assign w_s_abs    = r_s[FX_W-1] ? ('0 - fx_sext(r_s)) : fx_sext(r_s);
    assign w_conv_hit = (w_s_abs <= {1'b0, r_eps});
    assign w_iter_nx  = r_iter + ITER_W'(1);
    assign w_cap_hit  = (w_iter_nx == ITER_W'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_lr    <= '0;
            r_eps   <= '0;
            r_x     <= '0;
            r_g     <= '0;
            r_s     <= '0;
            r_x_out <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_conv  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.coef_a;
                        r_b     <= bus.coef_b;
                        r_lr    <= bus.lr;
                        r_eps   <= bus.eps;
                        r_x     <= bus.x_init;
                        r_iter  <= '0;
                        r_conv  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= GRAD;
                    end
                end
                GRAD: begin
                    r_g     <= w_g;
                    r_state <= STEP;
                end
                STEP: begin
                    r_s     <= w_s;
                    r_state <= UPDATE;
                end
                UPDATE: begin
                    r_x    <= w_x_nx;
                    r_iter <= w_iter_nx;
                    if (w_conv_hit || w_cap_hit) begin
                        r_x_out <= w_x_nx;
                        r_conv  <= w_conv_hit;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= GRAD;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.out_valid  = r_valid;
    assign bus.x_out      = r_x_out;
    assign bus.iter_count = r_iter;
    assign bus.converged  = r_conv;
endmodule

// File: tb/tb_grad_descent_1d.sv
// Scoreboard bench for grad_descent_1d: three instances (MAX_ITER 255/16/4) on a shared clock.
module tb_grad_descent_1d;
    import gd_pkg::*;

    typedef struct packed {
        logic [15:0] x;
        logic [7:0]  it;
        logic        conv;
        logic [7:0]  lat;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] t_a, t_b, t_lr, t_x0, t_eps;
    logic [2:0]  t_start, t_ready;
    logic [2:0]  o_busy, o_valid, o_conv;
    logic [15:0] o_x  [3];
    logic [7:0]  o_it [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    grad_descent_1d_if #(.ITER_W(8)) bus [3] ();

    for (genvar i = 0; i < 3; i++) begin : g_wire
        assign bus[i].start     = t_start[i];
        assign bus[i].coef_a    = t_a;
        assign bus[i].coef_b    = t_b;
        assign bus[i].lr        = t_lr;
        assign bus[i].x_init    = t_x0;
        assign bus[i].eps       = t_eps;
        assign bus[i].out_ready = t_ready[i];
        assign o_busy[i]        = bus[i].busy;
        assign o_valid[i]       = bus[i].out_valid;
        assign o_conv[i]        = bus[i].converged;
        assign o_x[i]           = bus[i].x_out;
        assign o_it[i]          = bus[i].iter_count;
    end

    grad_descent_1d u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
    grad_descent_1d #(.MAX_ITER(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
    grad_descent_1d #(.MAX_ITER(4))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus[2]));

    always #5 clk = ~clk;

    task automatic launch(input int d, input logic [15:0] a, b, lr, x0, eps);
        @(negedge clk);
        t_a = a; t_b = b; t_lr = lr; t_x0 = x0; t_eps = eps;
        t_start[d] = 1'b1;
        @(negedge clk);
        t_start[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int budget, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (o_valid[d] !== 1'b1) begin
            if (cyc >= budget) begin
                to = 1'b1;
                return;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake(input int d);
        t_ready[d] = 1'b1;
        @(negedge clk);
        t_ready[d] = 1'b0;
    endtask

    // Pushes the expectation, runs one job, scrambles the live inputs mid-run,
    // then pops and compares once out_valid appears. Leaves the result unacknowledged.
    task automatic sb_run(input string name, input int d,
                          input logic [15:0] a, b, lr, x0, eps, input exp_t e);
        exp_t got_e;
        int   cyc;
        bit   to;
        sb.push_back(e);
        launch(d, a, b, lr, x0, eps);
        n_tests++;
        if (o_busy[d] !== 1'b1)
            $display("FAIL %s_busy: got %b, expected 1", name, o_busy[d]);
        t_a = 16'h7FFF; t_b = 16'h8000; t_lr = 16'h1234; t_x0 = 16'h5555; t_eps = 16'hFFFF;
        wait_valid(d, 800, cyc, to);
        got_e = sb.pop_front();
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, expected 1", name, o_valid[d], cyc);
        end else begin
            if (cyc != int'(got_e.lat)) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d, expected %0d", name, cyc, got_e.lat);
            end
            n_tests++;
            if (o_x[d] !== got_e.x) begin
                n_fail++;
                $display("FAIL %s_x: got %h, expected %h", name, o_x[d], got_e.x);
            end
            n_tests++;
            if (o_it[d] !== got_e.it) begin
                n_fail++;
                $display("FAIL %s_iter: got %0d, expected %0d", name, o_it[d], got_e.it);
            end
            n_tests++;
            if (o_conv[d] !== got_e.conv) begin
                n_fail++;
                $display("FAIL %s_conv: got %b, expected %b", name, o_conv[d], got_e.conv);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({o_busy[d], o_valid[d], o_conv[d], o_x[d], o_it[d]} !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_outputs%0d: got busy=%b valid=%b conv=%b x=%h it=%0d, expected all 0",
                         d, o_busy[d], o_valid[d], o_conv[d], o_x[d], o_it[d]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_release(input string name, input int d);
        handshake(d);
        n_tests++;
        if (o_busy[d] !== 1'b0 || o_valid[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: got busy=%b valid=%b, expected 0 0", name, o_busy[d], o_valid[d]);
        end
    endtask

    task automatic test_converge();
        sb_run("conv", 0, 16'h0100, 16'hFC00, 16'h0040, 16'h0000, 16'h0001,
               '{x: 16'h01FF, it: 8'd9, conv: 1'b1, lat: 8'd27});
        test_release("conv", 0);
    endtask

    task automatic test_cap();
        sb_run("cap", 1, 16'h0100, 16'hFC00, 16'h0100, 16'h0000, 16'h0001,
               '{x: 16'h0000, it: 8'd16, conv: 1'b0, lat: 8'd48});
        test_release("cap", 1);
    endtask

    task automatic test_saturate();
        logic [15:0] ex;
`ifdef GD_SATURATE_EN
        ex = 16'hB801;
`else
        ex = 16'h6000;
`endif
        sb_run("sat", 2, 16'h0100, 16'hFC00, 16'h0200, 16'h0000, 16'h0000,
               '{x: ex, it: 8'd4, conv: 1'b0, lat: 8'd12});
        test_release("sat", 2);
    endtask

    task automatic test_backpressure();
        sb_run("bp", 0, 16'h0100, 16'hFC00, 16'h0040, 16'h0000, 16'h0001,
               '{x: 16'h01FF, it: 8'd9, conv: 1'b1, lat: 8'd27});
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                t_x0       = 16'h0100;
                t_start[0] = 1'b1;
            end
            @(negedge clk);
            n_tests++;
            if (o_valid[0] !== 1'b1 || o_busy[0] !== 1'b1 || o_x[0] !== 16'h01FF ||
                o_it[0] !== 8'd9 || o_conv[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b busy=%b x=%h it=%0d conv=%b, expected 1 1 01ff 9 1",
                         i, o_valid[0], o_busy[0], o_x[0], o_it[0], o_conv[0]);
            end
        end
        t_start[0] = 1'b0;
        test_release("bp", 0);
        sb_run("bp_restart", 0, 16'h0100, 16'hFC00, 16'h0040, 16'h0000, 16'h0001,
               '{x: 16'h01FF, it: 8'd9, conv: 1'b1, lat: 8'd27});
        test_release("bp_restart", 0);
    endtask

    task automatic test_reset_midrun();
        launch(0, 16'h0100, 16'hFC00, 16'h0040, 16'h0000, 16'h0001);
        repeat (7) @(negedge clk);
        n_tests++;
        if (o_it[0] !== 8'd2) begin
            n_fail++;
            $display("FAIL midrun_iter: got %0d, expected 2", o_it[0]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_busy[0], o_valid[0], o_conv[0], o_x[0], o_it[0]} !== 27'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b valid=%b conv=%b x=%h it=%0d, expected all 0",
                     o_busy[0], o_valid[0], o_conv[0], o_x[0], o_it[0]);
        end
        n_tests++;
        if (u_dut0.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL midrun_state: got %0d, expected %0d", u_dut0.r_state, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_run("rerun", 0, 16'h0100, 16'hFC00, 16'h0040, 16'h0000, 16'h0001,
               '{x: 16'h01FF, it: 8'd9, conv: 1'b1, lat: 8'd27});
        test_release("rerun", 0);
    endtask

    initial begin
        t_a = '0; t_b = '0; t_lr = '0; t_x0 = '0; t_eps = '0;
        t_start = '0;
        t_ready = '0;
        test_reset();
        test_converge();
        test_cap();
        test_saturate();
        test_backpressure();
        test_reset_midrun();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/grad_descent_1d.md
# grad_descent_1d

Iterative gradient-descent engine for a 1-D quadratic cost f(x) = a·x² + b·x, all values 8.8 signed fixed point. It is loaded with coefficients, learning rate, start point and tolerance, and iterates x ← x − lr·(2a·x + b) until the step is within tolerance or an iteration cap is hit. The final 8.8 x is presented on a valid/ready output and feeds snap_to_closest_int, which rounds it to the 8-bit integer answer.

## Interface
- MAX_ITER, default 255: iteration cap, range 1..255.
- ITER_W, default 8: width of the iteration counter; must hold MAX_ITER.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- coef_a  in  16  a, 8.8 signed.
- coef_b  in  16  b, 8.8 signed.
- lr  in  16  learning rate, 8.8 signed.
- x_init  in  16  start point, 8.8 signed.
- eps  in  16  tolerance, 8.8, treated as unsigned magnitude.
- busy  out  1  high from start acceptance until output handshake completes.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- x_out  out  16  final x, 8.8 signed.
- iter_count  out  ITER_W  iterations executed.
- converged  out  1  1 = stopped on tolerance, 0 = stopped on cap.

## Operation
- Reset values: busy=0, out_valid=0, x_out=0, iter_count=0, converged=0; FSM in IDLE.
- States:
  - IDLE: on start=1, latch all inputs, set x=x_init, iter=0, go to GRAD. busy rises.
  - GRAD: g = sat(2·((a·x)>>>8)) + b, with saturation on the add.
  - STEP: s = (lr·g)>>>8.
  - UPDATE: x = x − s; iter += 1.
    - If |s| ≤ eps, set converged=1 and go to DONE.
    - Else if iter == MAX_ITER, set converged=0 and go to DONE.
    - Else go to GRAD.
  - DONE: out_valid=1 with x_out/iter_count/converged stable. On out_valid&out_ready, go to IDLE; out_valid and busy clear next cycle.
- Arithmetic:
  - Products are 16×16 signed → 32 bits; the result is bits [23:8], i.e. an arithmetic shift that truncates toward −∞.
  - |s| is computed at 17 bits, so that −128.0 compares correctly.
- start outside IDLE is ignored. Latched inputs are not affected by later input changes.
- Reset asserted mid-run forces IDLE and reset values immediately; the run is discarded.

## Timing
- Start accept edge E0. Each iteration takes 3 cycles (GRAD, STEP, UPDATE).
- out_valid is high after edge E(3·N), where N = final iter_count.
- out_valid is held until handshake; outputs do not change while waiting.
- Minimum start-to-start interval is 3·N+2 cycles.

## Configuration
- GD_SATURATE_EN defined: every product truncation, the ×2, and both add/sub saturate to [0x8000, 0x7FFF].
- Not defined: all of these wrap modulo 2¹⁶. Latency is identical in both cases.

## Structure
- Package gd_pkg holds:
  - the state enum (IDLE/GRAD/STEP/UPDATE/DONE);
  - FX_W=16 and FX_FRAC=8;
  - FX_MAX=16'h7FFF and FX_MIN=16'h8000.
- One sub-module, fx_mul_q88: signed 8.8 multiply with shift and optional saturation. It is used for the a·x and lr·g products.

## Test plan
- Convergence: a=0x0100, b=0xFC00, lr=0x0040, x_init=0, eps=0x0001 → x_out=0x01FF, iter_count=9, converged=1, out_valid 27 cycles after accept.
- Cap: same a and b, lr=0x0100, MAX_ITER=16, eps=0x0001 (x alternates 0/4.0) → x_out=0x0000, iter_count=16, converged=0.
- Saturation: same a and b, lr=0x0200, x_init=0, MAX_ITER=4, eps=0 → x_out=0xB801 with GD_SATURATE_EN, 0x6000 without; converged=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable and start ignored. Then a one-cycle out_ready → busy low the next cycle and a new start is accepted.
- Reset mid-run: assert rst_n=0 during iteration 3 → all outputs 0 and FSM in IDLE. A fresh convergence run then reproduces the first scenario exactly.
